divide_by_n_prog: RTL and testbench
===================================

# divide_by_n_prog

Runtime-programmable integer clock divider that generalises the fixed even-only divider. It produces a 50 %-duty `clk_out` for any divisor N ≥ 2, even or odd. It accepts divisor changes and start/stop requests only at period boundaries, so the output never glitches or emits a runt pulse. It sits beside the even divider in the clock-generation area and feeds downstream logic with a derived clock plus a synchronous per-period `tick` enable.

## Interface
- `WIDTH`, 8, width of divisor input and internal period counter
- `DEFAULT_DIV`, 2, divisor loaded at reset; must satisfy 2 ≤ value ≤ 2^WIDTH−1
- `clk`  input  1  source clock; all logic on posedge except the odd-duty half-cycle flop (negedge)
- `rst_n`  input  1  asynchronous active-low reset
- `en`  input  1  run request; sampled on posedge
- `div_load`  input  1  one-cycle strobe; latch `div_i` as the pending divisor
- `div_i`  input  WIDTH  requested divisor; values 0 and 1 are clamped to 2
- `div_ack`  output  1  one-cycle pulse on the cycle after `div_load` is accepted
- `div_cur`  output  WIDTH  divisor currently governing `clk_out`
- `tick`  output  1  one-cycle posedge-domain pulse in the first cycle of each output period
- `clk_out`  output  1  divided clock

## Operation
- FSM states:
  - IDLE: output low, counter held at 0.
  - RUN: counting.
  - DRAIN: `en` has dropped; finish the current period.
- FSM transitions:
  - IDLE→RUN when `en`=1.
  - RUN→DRAIN when `en`=0.
  - DRAIN→IDLE at period wrap.
  - DRAIN→RUN if `en` returns to 1 before the wrap; the period continues without a restart.
- Counter `cnt` counts 0..N−1 in RUN/DRAIN and wraps to 0. Here N = `div_cur` and H = ceil(N/2).
- `q_pos` (posedge flop) is 1 while `cnt` < H.
- Even N: `clk_out` = `q_pos`, giving N/2 cycles high and N/2 cycles low.
- Odd N: `q_neg` is `q_pos` re-registered on negedge, and `clk_out` = `q_pos` & `q_neg`. This gives N/2 cycles high (half-cycle resolution) and exact 50 % duty.
- Divisor update:
  - `div_load` writes a pending register (last write wins) and sets a pending flag.
  - At the next wrap, or at any posedge while in IDLE, `div_cur` takes the pending value and the flag clears.
  - If `div_load` coincides with a wrap cycle (`cnt`=N−1), `div_i` applies directly at that wrap.
- `div_ack` is issued for every accepted `div_load`, including clamped values.
- `tick` = 1 in each cycle where `cnt`=0 and the state is RUN or DRAIN.

## Timing
- Reset values: `cnt`=0, state IDLE, `q_pos`=`q_neg`=0, `clk_out`=0, `tick`=0, `div_ack`=0, `div_cur`=DEFAULT_DIV, pending flag 0.
- Start latency: with `en`=1 at posedge k in IDLE, `clk_out` rises just after posedge k+1. The odd case additionally needs the following negedge. `tick`=1 in cycle k+1.
- Output period is exactly N `clk` cycles. The first period after a divisor change has the new length; no intermediate period length occurs.
- Stop: `en` deasserted mid-period → the period completes and `clk_out` stays low from the wrap onward. No truncated high phase.
- `rst_n` asserted mid-period: all outputs go to reset values immediately (asynchronous), and the pending divisor is discarded. After release, restart follows the start-latency rule.
- Maximum divisor 2^WIDTH−1: `cnt` never overflows; H is computed in WIDTH bits as (N>>1)+N[0].

## Structure
- Package `clk_div_pkg`:
  - state enum `{IDLE, RUN, DRAIN}`
  - `MIN_DIV`=2
  - function `div_clamp(div)`
- One sub-module `clk_div_duty`: inputs `q_pos`, `odd`; output `clk_out`. It contains the negedge flop and the final AND/mux. This isolates the only negedge logic for timing constraints and lint waivers.

## Test plan
- Default N=2, `en`=1 after reset: `clk_out` toggles every cycle; `tick` every cycle; first rise one cycle after `en` is sampled.
- `div_load` with `div_i`=3: after the next wrap, period is 3 cycles and high time is 1.5 cycles, measured on both edges; `div_cur`=3.
- Running N=4, load 6 when `cnt`=1: the current period stays 4 cycles and the following periods are 6 cycles; `div_ack` pulses once.
- `en` dropped at `cnt`=1 with N=8: `clk_out` completes 4 high and 4 low cycles, then stays 0; state IDLE; re-raising `en` restarts cleanly.
- `div_i`=0 and `div_i`=1: both yield `div_cur`=2. `div_i`=255 with WIDTH=8: period 255 cycles and high time 127.5 cycles.
- Reset asserted mid-high-phase at N=5 with a pending load of 7: `clk_out` is 0 immediately and `div_cur`=DEFAULT_DIV after release.

Source files
------------

// File: rtl/divide_by_n_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the run-control state encoding and the divisor clamp rule.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // Divisors below two cannot form a high and a low phase, so they are lifted to two.
    function automatic int unsigned div_clamp(input int unsigned div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/divide_by_n_prog_duty.sv
// Output shaping stage: the only negedge flop in the divider.
// Odd divisors AND the posedge phase with its half-cycle-delayed copy for exact 50% duty.
module clk_div_duty (
    input  logic clk,
    input  logic rst_n,
    input  logic q_pos,
    input  logic odd,
    output logic clk_out
);
    logic q_neg_q, q_neg_d;

    always_comb begin
        q_neg_d = q_pos;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
        end
    end

    assign clk_out = odd ? (q_pos & q_neg_q) : q_pos;

endmodule

// File: rtl/divide_by_n_prog.sv
// Runtime-programmable integer clock divider with 50% duty for any N >= 2.
// Divisor changes and start/stop requests only take effect at period boundaries.
module divide_by_n_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_i,
    output logic             div_ack,
    output logic [WIDTH-1:0] div_cur,
    output logic             tick,
    output logic             clk_out
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             q_pos_q, q_pos_d;
    logic             tick_q, tick_d;
    logic             div_ack_q, div_ack_d;

    logic [WIDTH-1:0] div_i_clamped;
    logic [WIDTH-1:0] half;
    logic             running;
    logic             wrap;
    logic             apply_div;

    always_comb begin
        div_i_clamped = WIDTH'(div_clamp(32'(div_i)));
        half          = (div_cur_q >> 1) + WIDTH'(div_cur_q[0]);
        running       = (state_q != IDLE);
        wrap          = running && (cnt_q == div_cur_q - WIDTH'(1));
        apply_div     = wrap || !running;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = wrap ? IDLE : DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (!running || wrap) ? '0 : cnt_q + WIDTH'(1);

        // The output phase lags the counter by one cycle, so a new period never shortens the last low cycle.
        q_pos_d = running && (cnt_q < half);
        tick_d  = running && (cnt_q == '0);

        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (apply_div) begin
            if (div_load) begin
                div_cur_d = div_i_clamped;
            end else if (pend_q) begin
                div_cur_d = pend_val_q;
            end
            pend_d = 1'b0;
        end else if (div_load) begin
            pend_d     = 1'b1;
            pend_val_d = div_i_clamped;
        end

        div_ack_d = div_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_cur_q  <= WIDTH'(DEFAULT_DIV);
            pend_val_q <= WIDTH'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            q_pos_q    <= 1'b0;
            tick_q     <= 1'b0;
            div_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            q_pos_q    <= q_pos_d;
            tick_q     <= tick_d;
            div_ack_q  <= div_ack_d;
        end
    end

    clk_div_duty u_duty (
        .clk     (clk),
        .rst_n   (rst_n),
        .q_pos   (q_pos_q),
        .odd     (div_cur_q[0]),
        .clk_out (clk_out)
    );

    assign div_ack = div_ack_q;
    assign div_cur = div_cur_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_divide_by_n_prog.sv
// Self-checking bench for divide_by_n_prog: directed scenarios plus randomized traffic
// compared against a period-level waveform model (start cycle, length, half-cycle high window).
module tb_divide_by_n_prog;
    localparam int WIDTH   = 8;
    localparam int DEF_DIV = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             div_load;
    logic [WIDTH-1:0] div_i;
    logic             div_ack;
    logic [WIDTH-1:0] div_cur;
    logic             tick;
    logic             clk_out;

    int checks = 0;
    int errors = 0;

    // Reference model: the current output period is described by its start cycle and length.
    int cyc = 0;
    bit m_run;
    int m_ostart;
    int m_pn;
    int m_div;
    bit m_pend;
    int m_pend_val;
    bit m_ack;

    logic             o_clk_p, o_clk_n, o_tick, o_ack;
    logic [WIDTH-1:0] o_div;
    bit               e_clk_p, e_clk_n, e_tick, e_ack;
    int               e_div;

    divide_by_n_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_load (div_load),
        .div_i    (div_i),
        .div_ack  (div_ack),
        .div_cur  (div_cur),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_run    = 1'b0;
        m_ostart = 0;
        m_pn     = DEF_DIV;
        m_div    = DEF_DIV;
        m_pend   = 1'b0;
        m_ack    = 1'b0;
    endtask

    // Boundaries are idle edges and the last edge of a running period; only there do N and run state change.
    task automatic model_edge();
        int ld;
        bit boundary;
        cyc++;
        ld = (int'(div_i) < 2) ? 2 : int'(div_i);
        boundary = !m_run || (cyc == m_ostart + m_pn - 1);
        if (boundary) begin
            if (div_load) m_div = ld;
            else if (m_pend) m_div = m_pend_val;
            m_pend = 1'b0;
        end else if (div_load) begin
            m_pend = 1'b1;
            m_pend_val = ld;
        end
        m_ack = div_load;
        if (boundary) begin
            if (en) begin
                m_run = 1'b1;
                m_ostart = cyc + 1;
                m_pn = m_div;
            end else begin
                m_run = 1'b0;
            end
        end
    endtask

    // Even N: high for the first N half-cycles. Odd N: high from half-cycle 1 through N.
    function automatic bit exp_clk(input bit second_half);
        int h;
        if (!m_run || cyc < m_ostart) return 1'b0;
        h = 2 * (cyc - m_ostart) + int'(second_half);
        if (m_pn % 2 == 0) return (h < m_pn);
        return (h >= 1) && (h <= m_pn);
    endfunction

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
        o_clk_p = clk_out;
        o_tick  = tick;
        o_div   = div_cur;
        o_ack   = div_ack;
        e_clk_p = exp_clk(1'b0);
        e_tick  = m_run && (cyc == m_ostart);
        e_div   = m_div;
        e_ack   = m_ack;
        @(negedge clk);
        #1;
        o_clk_n = clk_out;
        e_clk_n = exp_clk(1'b1);
        div_load = 1'b0;
    endtask

    task automatic wait_tick(input int need_div, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            advance();
            if (o_tick === 1'b1 && (need_div == 0 || int'(o_div) == need_div)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Starts on a tick cycle; returns cycles until the next tick and high half-cycles in between.
    task automatic measure_period(output int len, output int hi, output int acks);
        len  = 1;
        hi   = int'(o_clk_p) + int'(o_clk_n);
        acks = 0;
        for (int i = 0; i < 600; i++) begin
            advance();
            acks += int'(o_ack);
            if (o_tick === 1'b1) break;
            hi += int'(o_clk_p) + int'(o_clk_n);
            len++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_out got=%0b exp=0", clk_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%0b exp=0", tick); end
        checks++; if (div_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_ack got=%0b exp=0", div_ack); end
        checks++; if (div_cur !== WIDTH'(DEF_DIV)) begin errors++; $display("[TB] FAIL reset_div_cur got=%0d exp=%0d", div_cur, DEF_DIV); end
        rst_n = 1'b1;
    endtask

    task automatic test_default_n2();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            advance();
            checks++; if (o_clk_p !== e_clk_p) begin errors++; $display("[TB] FAIL n2_clk_pos cyc=%0d got=%0b exp=%0b", cyc, o_clk_p, e_clk_p); end
            checks++; if (o_clk_n !== e_clk_n) begin errors++; $display("[TB] FAIL n2_clk_neg cyc=%0d got=%0b exp=%0b", cyc, o_clk_n, e_clk_n); end
            checks++; if (o_tick !== e_tick) begin errors++; $display("[TB] FAIL n2_tick cyc=%0d got=%0b exp=%0b", cyc, o_tick, e_tick); end
            if (i == 0) begin
                checks++; if (o_clk_p !== 1'b0) begin errors++; $display("[TB] FAIL n2_start_low got=%0b exp=0", o_clk_p); end
            end
            if (i == 1) begin
                checks++; if (o_clk_p !== 1'b1 || o_tick !== 1'b1) begin errors++; $display("[TB] FAIL n2_first_rise got=%0b/%0b exp=1/1", o_clk_p, o_tick); end
            end
        end
    endtask

    task automatic test_odd_load3();
        bit found;
        int len, hi, acks;
        div_i = 8'd3;
        div_load = 1'b1;
        advance();
        checks++; if (o_ack !== 1'b1) begin errors++; $display("[TB] FAIL n3_ack got=%0b exp=1", o_ack); end
        for (int i = 0; i < 12; i++) begin
            advance();
            checks++; if (o_clk_p !== e_clk_p) begin errors++; $display("[TB] FAIL n3_clk_pos cyc=%0d got=%0b exp=%0b", cyc, o_clk_p, e_clk_p); end
            checks++; if (o_clk_n !== e_clk_n) begin errors++; $display("[TB] FAIL n3_clk_neg cyc=%0d got=%0b exp=%0b", cyc, o_clk_n, e_clk_n); end
            checks++; if (o_tick !== e_tick) begin errors++; $display("[TB] FAIL n3_tick cyc=%0d got=%0b exp=%0b", cyc, o_tick, e_tick); end
        end
        wait_tick(3, 10, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL n3_wait_tick got=timeout exp=tick"); end
        checks++; if (o_div !== 8'd3) begin errors++; $display("[TB] FAIL n3_div_cur got=%0d exp=3", o_div); end
        measure_period(len, hi, acks);
        checks++; if (len != 3) begin errors++; $display("[TB] FAIL n3_period got=%0d exp=3", len); end
        checks++; if (hi != 3) begin errors++; $display("[TB] FAIL n3_high_halves got=%0d exp=3", hi); end
    endtask

    task automatic test_load_midperiod();
        bit found;
        int len, hi, acks;
        div_i = 8'd4;
        div_load = 1'b1;
        advance();
        wait_tick(4, 20, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL n4_wait_tick got=timeout exp=tick"); end
        div_i = 8'd6;
        div_load = 1'b1;
        measure_period(len, hi, acks);
        checks++; if (len != 4) begin errors++; $display("[TB] FAIL mid_old_period got=%0d exp=4", len); end
        checks++; if (hi != 4) begin errors++; $display("[TB] FAIL mid_old_high got=%0d exp=4", hi); end
        checks++; if (acks != 1) begin errors++; $display("[TB] FAIL mid_ack_count got=%0d exp=1", acks); end
        checks++; if (o_div !== 8'd6) begin errors++; $display("[TB] FAIL mid_div_cur got=%0d exp=6", o_div); end
        for (int p = 0; p < 2; p++) begin
            measure_period(len, hi, acks);
            checks++; if (len != 6) begin errors++; $display("[TB] FAIL mid_new_period p=%0d got=%0d exp=6", p, len); end
            checks++; if (hi != 6) begin errors++; $display("[TB] FAIL mid_new_high p=%0d got=%0d exp=6", p, hi); end
        end
    endtask

    task automatic test_stop();
        bit found;
        int hi_p, hi_all, ticks;
        div_i = 8'd8;
        div_load = 1'b1;
        advance();
        wait_tick(8, 30, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL n8_wait_tick got=timeout exp=tick"); end
        hi_p   = int'(o_clk_p);
        hi_all = int'(o_clk_p) + int'(o_clk_n);
        ticks  = 0;
        en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            advance();
            hi_p   += int'(o_clk_p);
            hi_all += int'(o_clk_p) + int'(o_clk_n);
            ticks  += int'(o_tick);
            checks++; if (o_clk_p !== e_clk_p) begin errors++; $display("[TB] FAIL stop_clk_pos cyc=%0d got=%0b exp=%0b", cyc, o_clk_p, e_clk_p); end
            checks++; if (o_clk_n !== e_clk_n) begin errors++; $display("[TB] FAIL stop_clk_neg cyc=%0d got=%0b exp=%0b", cyc, o_clk_n, e_clk_n); end
        end
        checks++; if (hi_p != 4) begin errors++; $display("[TB] FAIL stop_high_cycles got=%0d exp=4", hi_p); end
        checks++; if (hi_all != 8) begin errors++; $display("[TB] FAIL stop_high_halves got=%0d exp=8", hi_all); end
        checks++; if (ticks != 0) begin errors++; $display("[TB] FAIL stop_ticks got=%0d exp=0", ticks); end
        checks++; if (o_clk_p !== 1'b0 || o_clk_n !== 1'b0) begin errors++; $display("[TB] FAIL stop_stays_low got=%0b%0b exp=00", o_clk_p, o_clk_n); end
        en = 1'b1;
        advance();
        checks++; if (o_clk_p !== 1'b0 || o_tick !== 1'b0) begin errors++; $display("[TB] FAIL restart_latency got=%0b/%0b exp=0/0", o_clk_p, o_tick); end
        advance();
        checks++; if (o_clk_p !== 1'b1 || o_tick !== 1'b1) begin errors++; $display("[TB] FAIL restart_rise got=%0b/%0b exp=1/1", o_clk_p, o_tick); end
        checks++; if (o_div !== 8'd8) begin errors++; $display("[TB] FAIL restart_div got=%0d exp=8", o_div); end
    endtask

    task automatic test_clamp();
        bit found;
        int len, hi, acks;
        int vals[5] = '{5, 0, 7, 1, 255};
        int exps[5] = '{5, 2, 7, 2, 255};
        en = 1'b0;
        for (int i = 0; i < 600 && m_run; i++) advance();
        advance();
        checks++; if (o_clk_p !== 1'b0 || o_tick !== 1'b0) begin errors++; $display("[TB] FAIL idle_quiet got=%0b/%0b exp=0/0", o_clk_p, o_tick); end
        for (int k = 0; k < 5; k++) begin
            div_i = WIDTH'(vals[k]);
            div_load = 1'b1;
            advance();
            checks++; if (int'(o_div) != exps[k] || o_ack !== 1'b1) begin errors++; $display("[TB] FAIL clamp_%0d got=%0d/%0b exp=%0d/1", vals[k], o_div, o_ack, exps[k]); end
        end
        en = 1'b1;
        wait_tick(255, 5, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL n255_wait_tick got=timeout exp=tick"); end
        measure_period(len, hi, acks);
        checks++; if (len != 255) begin errors++; $display("[TB] FAIL n255_period got=%0d exp=255", len); end
        checks++; if (hi != 255) begin errors++; $display("[TB] FAIL n255_high_halves got=%0d exp=255", hi); end
        en = 1'b0;
        for (int i = 0; i < 600 && m_run; i++) advance();
    endtask

    task automatic test_reset_mid();
        bit found;
        div_i = 8'd5;
        div_load = 1'b1;
        en = 1'b1;
        advance();
        wait_tick(5, 10, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL n5_wait_tick got=timeout exp=tick"); end
        div_i = 8'd7;
        div_load = 1'b1;
        advance();
        checks++; if (o_clk_n !== 1'b1 || o_ack !== 1'b1) begin errors++; $display("[TB] FAIL n5_high_phase got=%0b/%0b exp=1/1", o_clk_n, o_ack); end
        rst_n = 1'b0;
        #1;
        checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_clk_out got=%0b exp=0", clk_out); end
        checks++; if (div_ack !== 1'b0 || tick !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pulses got=%0b/%0b exp=0/0", div_ack, tick); end
        checks++; if (div_cur !== WIDTH'(DEF_DIV)) begin errors++; $display("[TB] FAIL rst_mid_div_cur got=%0d exp=%0d", div_cur, DEF_DIV); end
        model_reset();
        #1;
        rst_n = 1'b1;
        advance();
        checks++; if (o_div !== WIDTH'(DEF_DIV)) begin errors++; $display("[TB] FAIL rst_pending_dropped got=%0d exp=%0d", o_div, DEF_DIV); end
        checks++; if (o_clk_p !== 1'b0) begin errors++; $display("[TB] FAIL rst_restart_latency got=%0b exp=0", o_clk_p); end
        advance();
        checks++; if (o_clk_p !== 1'b1 || o_tick !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart_rise got=%0b/%0b exp=1/1", o_clk_p, o_tick); end
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            div_load = ($urandom_range(0, 5) == 0);
            div_i = WIDTH'($urandom_range(0, 11));
            advance();
            checks++; if (o_clk_p !== e_clk_p) begin errors++; $display("[TB] FAIL rnd_clk_pos cyc=%0d got=%0b exp=%0b", cyc, o_clk_p, e_clk_p); end
            checks++; if (o_clk_n !== e_clk_n) begin errors++; $display("[TB] FAIL rnd_clk_neg cyc=%0d got=%0b exp=%0b", cyc, o_clk_n, e_clk_n); end
            checks++; if (o_tick !== e_tick) begin errors++; $display("[TB] FAIL rnd_tick cyc=%0d got=%0b exp=%0b", cyc, o_tick, e_tick); end
            checks++; if (o_div !== e_div[WIDTH-1:0]) begin errors++; $display("[TB] FAIL rnd_div_cur cyc=%0d got=%0d exp=%0d", cyc, o_div, e_div); end
            checks++; if (o_ack !== e_ack) begin errors++; $display("[TB] FAIL rnd_div_ack cyc=%0d got=%0b exp=%0b", cyc, o_ack, e_ack); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_i    = '0;
        model_reset();
        test_reset();
        test_default_n2();
        test_odd_load3();
        test_load_midperiod();
        test_stop();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
